uart_tx: RTL
============

# uart_tx

UART transmitter that serialises bytes into the 8-data-bit, even-parity, 1-stop-bit frame consumed by the board's UART receiver. It runs on the same 16×-baud clock as the receiver and spends 16 clocks per bit. A small byte FIFO decouples the writer from the line, so bursts go out back-to-back. It sits between the design's byte producers and the `tx` pin, and also feeds the receiver directly in loopback tests.

## Interface
- `CLKS_PER_BIT`, 16: clocks per bit; must match the receiver's oversampling.
- `PARITY_EN`, 1: 1 = even parity bit after data; 0 = no parity bit.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥2.
- `clk  in  1`: 16×-baud clock. One clock domain; everything is on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `datain  in  8`: byte to send; sampled when `wrsig` is high.
- `wrsig  in  1`: single-cycle write strobe; pushes `datain` into the FIFO.
- `full  out  1`: FIFO holds `FIFO_DEPTH` bytes.
- `ovf  out  1`: one-cycle pulse when a write is dropped.
- `tx  out  1`: serial line; idles high; driven from a register.
- `idle  out  1`: high when no frame is in progress and the FIFO is empty.

## Operation
- Reset values: `tx`=1, `full`=0, `ovf`=0, `idle`=1. Reset also clears the FIFO and returns the FSM to IDLE.
- Frame order: start bit (0), data bits LSB first, parity (XOR of the 8 data bits, so the total count of ones is even), stop bit (1).
  - Frame length is 11×`CLKS_PER_BIT` clocks (176 with defaults).
  - With `PARITY_EN`=0 the frame is 10×`CLKS_PER_BIT` clocks.
- FSM states: IDLE → START → DATA → PARITY → STOP → (IDLE or START).
  - IDLE: if the FIFO is non-empty, pop one byte into the shift register, drive `tx`=0, go to START.
  - START, PARITY, STOP: each lasts `CLKS_PER_BIT` clocks, counted by the bit-timer.
  - DATA: 8 bit periods. The bit index runs 0..7 and the shift register shifts right each period.
  - PARITY is skipped when `PARITY_EN`=0.
  - Parity accumulates while each data bit is shifted out.
  - End of STOP: if the FIFO is non-empty, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- Bit-timer: counts 0..`CLKS_PER_BIT`-1 and wraps. The width is $clog2(`CLKS_PER_BIT`).
- FIFO count is 0..`FIFO_DEPTH`; pointers wrap modulo `FIFO_DEPTH`.
- Write while full:
  - Dropped if no pop occurs on the same edge; `ovf` pulses.
  - Accepted if a pop occurs on the same edge; count is unchanged and `full` stays 1.
- Write to an empty FIFO while the FSM is in IDLE: the byte is stored on that edge and popped on the next edge. There is no bypass path.
- Asserting `rst` mid-frame aborts the frame: `tx` goes high asynchronously and queued bytes are lost.
- `datain` is ignored when `wrsig`=0.

## Timing
- `wrsig` sampled at edge E with an empty FIFO and the FSM in IDLE:
  - `tx` falls at edge E+2.
  - `idle` falls at edge E+1.
- Each bit holds `tx` constant for exactly `CLKS_PER_BIT` clocks.
- Back-to-back frames start exactly 176 clocks apart with defaults.
- `idle` rises on the edge that ends the last STOP period when the FIFO is empty.
- `full` and `ovf` are registered; both update on the edge of the write or pop that changes them.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_BITS`=8 and `UART_OVERSAMPLE`=16.
  - The `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
  - An even-parity function, also used by the receiver's checker.
- One sub-module, `uart_tx_fifo`: a synchronous FIFO with push, pop, dout, full, empty, count and a same-edge push/pop rule. The FSM and shift register stay in `uart_tx`.

## Test plan
- Reset: release `rst` → `tx`=1, `idle`=1, `full`=0, `ovf`=0; `tx` stays 1 for 500 clocks with no writes.
- Write 0xA5 at edge E:
  - `tx`=0 at E+2 for 16 clocks.
  - Then bits 1,0,1,0,0,1,0,1 for 16 clocks each, parity 0, stop 1.
  - `idle` rises 176 clocks after E+2.
  - Looped into the receiver: `dataout`=0xA5, `dataerror`=0, `frameerror`=0.
- Write 0x07 → parity bit 1; receiver loopback reports `dataout`=0x07, `dataerror`=0.
- Writes 0x01..0x06 on edges E..E+5:
  - 0x01..0x05 are sent back-to-back at 176-clock spacing.
  - `full`=1 after E+4.
  - 0x06 is dropped and `ovf` pulses once after E+5.
- FIFO full, `wrsig` on the exact edge that ends STOP and pops → byte accepted, `ovf`=0, `full` stays 1, byte sent in order.
- `rst` during data bit 3 of 0x3C with 2 bytes queued → `tx`=1 immediately, `idle`=1, FIFO empty. A following write of 0x5A transmits a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, transmitter FSM states and the
// even-parity helper used by both the transmitter and the receiver checker.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_t;

    // Returns the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. A push while full is accepted
// only when a pop happens on the same edge, so the level stays at DEPTH.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == LvlW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + LvlW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - LvlW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, optional even parity, 1 stop bit, fed from a
// small byte FIFO so queued bytes leave back-to-back with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_OVERSAMPLE,
    parameter bit          PARITY_EN    = 1'b1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] datain,
    input  logic       wrsig,
    output logic       full,
    output logic       ovf,
    output logic       tx,
    output logic       idle
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);

    uart_tx_state_t            state_q, state_d;
    logic [CntW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [IdxW-1:0]           bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      parity_q, parity_d;
    logic                      tx_q, tx_d;
    logic                      idle_q, idle_d;
    logic                      ovf_q, ovf_d;

    logic                      pop;
    logic                      bit_done;
    logic [7:0]                fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [LvlW-1:0]           fifo_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wrsig),
        .pop   (pop),
        .din   (datain),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_done = (bit_cnt_q == CntW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_done ? '0 : bit_cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_dout;
                    parity_d = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    parity_d  = parity_q ^ shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + IdxW'(1);
                    if (bit_idx_q == IdxW'(UART_DATA_BITS - 1)) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (bit_done) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_d  = fifo_dout;
                        parity_d = 1'b0;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Line level trails the state by one clock, so every bit lasts a full period.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
            StParity: tx_d = parity_q;
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign idle_d = (state_q == StIdle) && fifo_empty;
    assign ovf_d  = wrsig && !pop && (fifo_count == LvlW'(FIFO_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            idle_q    <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            idle_q    <= idle_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx   = tx_q;
    assign idle = idle_q;
    assign ovf  = ovf_q;
    assign full = fifo_full;

endmodule
